// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter/sequencer in front of a 256x32 word memory; byte-enable writes become read-modify-write.
// Latency from grant cycle N: read -> rvalid N+2, full write -> N+2, partial write -> N+3, be=0 write -> N+1.
// Backpressure: requesters hold req until pX_gnt; one transaction in flight, gnt only in IDLE. Optional DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [3:0]        p0_be,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic [3:0]        p1_be,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              p1_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RESP} state_t;

    state_t              r_state;
    logic                r_last_grant;
    logic                r_port;
    logic                r_we;
    logic [MEM_AW-1:0]   r_idx;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [31:0]         r_mem_wdata;
    logic                r_p0_rvalid;
    logic                r_p1_rvalid;
    logic [31:0]         r_p0_rdata;
    logic [31:0]         r_p1_rdata;
    logic                r_p0_err;
    logic                r_p1_err;

    logic                w_idle;
    logic                w_any;
    logic                w_sel;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [31:0]         w_wdata;
    logic [3:0]          w_be;
    logic                w_bad;
    logic [31:0]         w_merge;
    logic                w_unused;

    // Grants are only offered while idle and out of reset, so nothing is accepted and then lost.
    assign w_idle = (r_state == ST_IDLE) && rst_n;
    assign w_any  = p0_req | p1_req;
    // Port 1 wins when alone, or on a tie when port 0 was served last.
    assign w_sel  = p1_req & (~p0_req | ~r_last_grant);

    assign p0_gnt = w_idle & w_any & ~w_sel;
    assign p1_gnt = w_idle & w_sel;

    assign w_we    = w_sel ? p1_we    : p0_we;
    assign w_addr  = w_sel ? p1_addr  : p0_addr;
    assign w_wdata = w_sel ? p1_wdata : p0_wdata;
    assign w_be    = w_sel ? p1_be    : p0_be;

`ifdef DMEM_ARB_RANGE_CHECK_EN
    // Anything outside the memory window is answered with an error and never touches memory.
    assign w_bad    = |w_addr[ADDR_W-1:MEM_AW+2];
    assign w_unused = ^w_addr[1:0];
`else
    // Upper address bits are dropped, so accesses wrap into the memory window.
    assign w_bad    = 1'b0;
    assign w_unused = ^{w_addr[ADDR_W-1:MEM_AW+2], w_addr[1:0]};
`endif

    // Read-modify-write merge: enabled lanes from the request, others from the current memory word.
    always_comb begin
        w_merge = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (r_be[i]) begin
                w_merge[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    // Sequencer: arbitrate in IDLE, then RD and/or WR as the request needs, then a one-cycle RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_we         <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_wdata  <= '0;
            r_p0_rvalid  <= 1'b0;
            r_p1_rvalid  <= 1'b0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
            r_p0_err     <= 1'b0;
            r_p1_err     <= 1'b0;
        end else begin
            // Strobes and response fields are single-cycle unless re-set below.
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
            r_p0_err    <= 1'b0;
            r_p1_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_port       <= w_sel;
                        r_last_grant <= w_sel;
                        r_we         <= w_we;
                        r_idx        <= w_addr[MEM_AW+1:2];
                        r_wdata      <= w_wdata;
                        r_be         <= w_be;
                        if (w_bad) begin
                            r_state <= ST_RESP;
                            if (w_sel) begin
                                r_p1_rvalid <= 1'b1;
                                r_p1_err    <= 1'b1;
                            end else begin
                                r_p0_rvalid <= 1'b1;
                                r_p0_err    <= 1'b1;
                            end
                        end else if (!w_we) begin
                            r_state    <= ST_RD;
                            r_mem_read <= 1'b1;
                        end else if (w_be == 4'hF) begin
                            r_state     <= ST_WR;
                            r_mem_write <= 1'b1;
                            r_mem_wdata <= w_wdata;
                        end else if (w_be == 4'h0) begin
                            r_state <= ST_RESP;
                            if (w_sel) r_p1_rvalid <= 1'b1;
                            else       r_p0_rvalid <= 1'b1;
                        end else begin
                            r_state    <= ST_RD;
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (r_we) begin
                        r_state     <= ST_WR;
                        r_mem_write <= 1'b1;
                        r_mem_wdata <= w_merge;
                    end else begin
                        r_state <= ST_RESP;
                        if (r_port) begin
                            r_p1_rvalid <= 1'b1;
                            r_p1_rdata  <= mem_rdata;
                        end else begin
                            r_p0_rvalid <= 1'b1;
                            r_p0_rdata  <= mem_rdata;
                        end
                    end
                end
                ST_WR: begin
                    r_state <= ST_RESP;
                    if (r_port) r_p1_rvalid <= 1'b1;
                    else        r_p0_rvalid <= 1'b1;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = {{(ADDR_W-MEM_AW-2){1'b0}}, r_idx, 2'b00};
    assign mem_wdata = r_mem_wdata;
    assign p0_rvalid = r_p0_rvalid;
    assign p0_rdata  = r_p0_rdata;
    assign p0_err    = r_p0_err;
    assign p1_rvalid = r_p1_rvalid;
    assign p1_rdata  = r_p1_rdata;
    assign p1_err    = r_p1_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural 256x32 memory.
// Expected responses are queued at grant time and checked (data, error, port, cycle) on rvalid.
// Scenario tasks add inline checks on memory strobes and stored words.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [3:0]  p0_be;
    logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [3:0]  p1_be;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_dat;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] due;
        logic        wr;
        logic [7:0]  idx;
        logic [31:0] wval;
    } exp_t;

    exp_t sb[$];
    logic gnt_log[$];

    dmem_arbiter #(.ADDR_W(32), .MEM_AW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural data memory: combinational read, write at the clock edge.
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_write)  mem[mem_addr[9:2]] <= mem_wdata;
        else if (pl_en) mem[pl_idx] <= pl_dat;
    end

    function automatic logic [31:0] pl_val(input int i);
        case (i)
            0:       return 32'h0000_0055;
            4:       return 32'hDEAD_BEEF;
            8:       return 32'h1122_3344;
            default: return 32'h0F0F_0000 ^ (32'(i) * 32'h0103_0507);
        endcase
    endfunction

    // Scoreboard: push expectations on grants, compare on rvalid, commit writes to the model on completion.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            gnt_log.delete();
        end else begin
            if (pl_en) ref_mem[pl_idx] = pl_dat;
            n_tests++;
            if ((mem_read && mem_write) || (p0_gnt && p1_gnt) || (p0_rvalid && p1_rvalid)) begin
                n_fail++;
                $display("FAIL exclusivity: rd=%0b wr=%0b gnt=%0b%0b rvalid=%0b%0b, required no pair high",
                         mem_read, mem_write, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid);
            end
            if (p0_gnt || p1_gnt) begin
                exp_t        e;
                logic        pt, we, bad;
                logic [31:0] ad, wd, old;
                logic [3:0]  be;
                pt  = p1_gnt;
                we  = pt ? p1_we : p0_we;
                ad  = pt ? p1_addr : p0_addr;
                wd  = pt ? p1_wdata : p0_wdata;
                be  = pt ? p1_be : p0_be;
                bad = 1'b0;
`ifdef DMEM_ARB_RANGE_CHECK_EN
                bad = |ad[31:10];
`endif
                e      = '0;
                e.port = pt;
                e.idx  = ad[9:2];
                old    = ref_mem[ad[9:2]];
                if (bad) begin
                    e.err = 1'b1;
                    e.due = 32'(cyc + 1);
                end else if (!we) begin
                    e.rdata = old;
                    e.due   = 32'(cyc + 2);
                end else if (be == 4'hF) begin
                    e.wr   = 1'b1;
                    e.wval = wd;
                    e.due  = 32'(cyc + 2);
                end else if (be == 4'h0) begin
                    e.due = 32'(cyc + 1);
                end else begin
                    e.wr   = 1'b1;
                    e.wval = old;
                    for (int b = 0; b < 4; b++) if (be[b]) e.wval[8*b +: 8] = wd[8*b +: 8];
                    e.due  = 32'(cyc + 3);
                end
                sb.push_back(e);
                gnt_log.push_back(pt);
            end
            if (p0_rvalid || p1_rvalid) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rvalid: rvalid=%0b%0b at cycle %0d, required none pending",
                             p0_rvalid, p1_rvalid, cyc);
                end else begin
                    exp_t        e;
                    logic        gp;
                    logic [31:0] rd, ord;
                    logic        er, oer;
                    e   = sb.pop_front();
                    gp  = p1_rvalid;
                    rd  = gp ? p1_rdata : p0_rdata;
                    er  = gp ? p1_err : p0_err;
                    ord = gp ? p0_rdata : p1_rdata;
                    oer = gp ? p0_err : p1_err;
                    if (gp !== e.port) begin
                        n_fail++;
                        $display("FAIL resp_port: got port %0d, required %0d", gp, e.port);
                    end
                    n_tests++;
                    if (rd !== e.rdata) begin
                        n_fail++;
                        $display("FAIL resp_rdata: got %h, required %h", rd, e.rdata);
                    end
                    n_tests++;
                    if (er !== e.err) begin
                        n_fail++;
                        $display("FAIL resp_err: got %0b, required %0b", er, e.err);
                    end
                    n_tests++;
                    if (32'(cyc) !== e.due) begin
                        n_fail++;
                        $display("FAIL resp_latency: rvalid at cycle %0d, required %0d", cyc, e.due);
                    end
                    n_tests++;
                    if (ord !== 32'h0 || oer !== 1'b0) begin
                        n_fail++;
                        $display("FAIL idle_port_outputs: rdata=%h err=%0b, required 0/0", ord, oer);
                    end
                    if (e.wr) ref_mem[e.idx] = e.wval;
                end
            end
        end
    end

    // Present a request on one port and hold it until granted; returns one cycle after the grant cycle.
    task automatic do_req(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        logic got;
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_be = be;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_be = be;
        end
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (port ? p1_gnt : p0_gnt) got = 1'b1;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL grant_timeout: port %0d not granted in 50 cycles, required grant", port);
        end
        @(posedge clk); #1;
        if (port) p1_req = 1'b0;
        else      p0_req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50 && sb.size() != 0; k++) begin
            @(negedge clk); #1;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL resp_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0; p0_be = 4'hF;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h4; p1_wdata = 32'h0; p1_be = 4'hF;
        pl_en = 1'b0; pl_idx = 8'h0; pl_dat = 32'h0;
        #12;
        n_tests++;
        if ({p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err, mem_read, mem_write} !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 00000000",
                     {p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err, mem_read, mem_write});
        end
        n_tests++;
        if ({p0_rdata, p1_rdata, mem_addr, mem_wdata} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_buses: rdata %h/%h addr %h wdata %h, required all 0",
                     p0_rdata, p1_rdata, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        p0_req = 1'b0; p1_req = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            pl_en = 1'b1; pl_idx = 8'(i); pl_dat = pl_val(i);
            @(posedge clk); #1;
        end
        pl_en = 1'b0;
    endtask

    task automatic test_read();
        @(posedge clk); #1;
        n_tests++;
        if (mem_read !== 1'b0) begin
            n_fail++; $display("FAIL read_idle_mem_read: got %0b, required 0", mem_read);
        end
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
        n_tests++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h10) begin
            n_fail++; $display("FAIL read_rd_cycle: mem_read=%0b addr=%h, required 1/00000010", mem_read, mem_addr);
        end
        @(posedge clk); #1;
        n_tests++;
        if (mem_read !== 1'b0 || p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL read_resp_cycle: mem_read=%0b rvalid=%0b rdata=%h, required 0/1/deadbeef",
                     mem_read, p0_rvalid, p0_rdata);
        end
        wait_idle();
    endtask

    task automatic test_partial_write();
        @(posedge clk); #1;
        do_req(1'b1, 1'b1, 32'h20, 32'h0000_AB00, 4'b0010);
        n_tests++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
            n_fail++; $display("FAIL rmw_rd: rd=%0b wr=%0b, required 1/0", mem_read, mem_write);
        end
        @(posedge clk); #1;
        n_tests++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== 32'h1122_AB44 || mem_addr !== 32'h20) begin
            n_fail++;
            $display("FAIL rmw_wr: wr=%0b rd=%0b wdata=%h addr=%h, required 1/0/1122ab44/00000020",
                     mem_write, mem_read, mem_wdata, mem_addr);
        end
        @(posedge clk); #1;
        n_tests++;
        if (mem_write !== 1'b0 || p1_rvalid !== 1'b1 || p1_rdata !== 32'h0 || p0_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmw_resp: wr=%0b p1_rvalid=%0b p1_rdata=%h p0_rvalid=%0b, required 0/1/0/0",
                     mem_write, p1_rvalid, p1_rdata, p0_rvalid);
        end
        n_tests++;
        if (mem[8] !== 32'h1122_AB44) begin
            n_fail++; $display("FAIL rmw_mem: word 8 = %h, required 1122ab44", mem[8]);
        end
        wait_idle();
    endtask

    task automatic test_be_zero();
        @(posedge clk); #1;
        do_req(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'h0);
        n_tests++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0 || p0_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL be0_resp: wr=%0b rd=%0b rvalid=%0b, required 0/0/1", mem_write, mem_read, p0_rvalid);
        end
        wait_idle();
        @(posedge clk); #1;
        n_tests++;
        if (mem[0] !== 32'h55) begin
            n_fail++; $display("FAIL be0_mem: word 0 = %h, required 00000055", mem[0]);
        end
    endtask

    task automatic test_range();
        @(posedge clk); #1;
        do_req(1'b0, 1'b0, 32'h400, 32'h0, 4'hF);
`ifdef DMEM_ARB_RANGE_CHECK_EN
        n_tests++;
        if (mem_read !== 1'b0 || p0_rvalid !== 1'b1 || p0_err !== 1'b1 || p0_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL range_err: rd=%0b rvalid=%0b err=%0b rdata=%h, required 0/1/1/0",
                     mem_read, p0_rvalid, p0_err, p0_rdata);
        end
`else
        n_tests++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL range_wrap_rd: rd=%0b addr=%h, required 1/00000000", mem_read, mem_addr);
        end
        @(posedge clk); #1;
        n_tests++;
        if (p0_rvalid !== 1'b1 || p0_err !== 1'b0 || p0_rdata !== 32'h55) begin
            n_fail++;
            $display("FAIL range_wrap_resp: rvalid=%0b err=%0b rdata=%h, required 1/0/00000055",
                     p0_rvalid, p0_err, p0_rdata);
        end
`endif
        wait_idle();
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        fork
            for (int k = 0; k < 4; k++) do_req(1'b0, 1'b1, 32'(k * 4), 32'hA000_0000 + 32'(k), 4'hF);
            for (int k = 0; k < 4; k++) do_req(1'b1, 1'b1, 32'(16 + k * 4), 32'hB000_0000 + 32'(k), 4'hF);
        join
        wait_idle();
        n_tests++;
        if (gnt_log.size() != 8) begin
            n_fail++; $display("FAIL rr_count: %0d grants, required 8", gnt_log.size());
        end
        for (int i = 0; i < gnt_log.size(); i++) begin
            n_tests++;
            if (gnt_log[i] !== ((i % 2) != 0)) begin
                n_fail++; $display("FAIL rr_order: grant %0d to port %0d, required %0d", i, gnt_log[i], i % 2);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            logic [31:0] ad;
            ad = {22'h0, 4'h0, 4'($urandom_range(15)), 2'($urandom_range(3))};
            @(posedge clk); #1;
            do_req(1'($urandom_range(1)), 1'($urandom_range(1)), ad, $urandom, 4'($urandom_range(15)));
            wait_idle();
        end
    endtask

    task automatic test_reset_in_wr();
        @(posedge clk); #1;
        do_req(1'b0, 1'b1, 32'h50, 32'h0000_00FF, 4'b0001);
        n_tests++;
        if (mem_read !== 1'b1) begin
            n_fail++; $display("FAIL rst_wr_rd: rd=%0b, required 1", mem_read);
        end
        @(posedge clk); #1;
        n_tests++;
        if (mem_write !== 1'b1) begin
            n_fail++; $display("FAIL rst_wr_wr: wr=%0b, required 1", mem_write);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_wr_drop: wr=%0b rd=%0b wdata=%h, required 0/0/0", mem_write, mem_read, mem_wdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
                n_fail++; $display("FAIL rst_wr_norvalid: rvalid=%0b%0b, required 00", p0_rvalid, p1_rvalid);
            end
        end
        n_tests++;
        if (mem[20] !== pl_val(20)) begin
            n_fail++; $display("FAIL rst_wr_mem: word 20 = %h, required %h", mem[20], pl_val(20));
        end
        @(posedge clk); #1;
        fork
            do_req(1'b0, 1'b0, 32'h50, 32'h0, 4'hF);
            do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        join
        wait_idle();
        n_tests++;
        if (gnt_log.size() != 2 || gnt_log[0] !== 1'b0 || gnt_log[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wr_first_grant: %0d grants, first to port %0d, required 2 grants starting at 0",
                     gnt_log.size(), gnt_log.size() > 0 ? gnt_log[0] : 1'bx);
        end
    endtask

    task automatic test_mem_final();
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            n_tests++;
            if (mem[i] !== ref_mem[i]) begin
                n_fail++; $display("FAIL mem_final: word %0d = %h, required %h", i, mem[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_partial_write();
        test_be_zero();
        test_range();
        test_back_to_back();
        test_random();
        test_reset_in_wr();
        test_mem_final();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the word-organised data memory (256 x 32, combinational read, write on clk edge).
- Port 0 is the CPU load/store unit; port 1 is the debug/DMA master.
- Grants one request at a time, round-robin.
- Memory supports only full-word writes, so byte-enable writes are converted into read-modify-write sequences.

Parameters:
- ADDR_W, 32, byte-address width of requester and memory addresses
- MEM_AW, 8, word-index bits used by memory (addr[MEM_AW+1:2]); 8 gives 1 KiB

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- p0_req  in  1  port 0 request; held with its fields until p0_gnt
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  ADDR_W  port 0 byte address; bits [1:0] ignored
- p0_wdata  in  32  port 0 write data
- p0_be  in  4  port 0 byte enables, bit i = byte lane i (wdata[8i+7:8i])
- p0_gnt  out  1  combinational accept pulse, one cycle
- p0_rvalid  out  1  registered completion pulse, one cycle (reads and writes)
- p0_rdata  out  32  read data, valid with p0_rvalid
- p0_err  out  1  error flag, valid with p0_rvalid
- p1_req, p1_we, p1_addr, p1_wdata, p1_be, p1_gnt, p1_rvalid, p1_rdata, p1_err: same as port 0, for port 1
- mem_read  out  1  to dmem mem_read
- mem_write  out  1  to dmem mem_write
- mem_addr  out  ADDR_W  to dmem addr, word aligned ({idx,2'b00})
- mem_wdata  out  32  to dmem write_data
- mem_rdata  in  32  from dmem read_data (combinational)

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset (async, rst_n low):
  - State IDLE; last_grant = 1, so port 0 wins the first tie.
  - All outputs 0 (gnt, rvalid, rdata, err, mem_read, mem_write, mem_addr, mem_wdata).
  - Any in-flight transaction is dropped with no response.
  - mem_write deasserts immediately.
- IDLE arbitration:
  - Only one requester: grant it.
  - Both requesting: grant the port not equal to last_grant.
  - pX_gnt asserted combinationally in that cycle.
  - we/addr/wdata/be latched into internal registers; last_grant updated.
  - gnt is never asserted outside IDLE.
- Next state from IDLE (N = grant cycle):
  - Read: RD.
  - Write with be = 4'hF: WR.
  - Write with be = 4'h0: RESP (no memory access).
  - Other partial write: RD, then WR.
- RD:
  - mem_read = 1, mem_addr = latched word address.
  - mem_rdata captured at the clock edge.
  - Reads: rdata register loaded with the full word.
  - Partial writes: merge register = captured word with enabled lanes replaced from wdata.
- WR:
  - mem_write = 1 for exactly one cycle.
  - mem_wdata = wdata for full writes, merged word for partial writes.
- RESP:
  - pX_rvalid = 1 for one cycle on the granted port only.
  - pX_rdata = read word for reads, 0 for writes.
  - Returns to IDLE; a new grant is possible in the cycle after RESP.
- Latency (grant at cycle N):
  - Read: rvalid at N+2.
  - Full write: memory written at end of N+1, rvalid at N+2.
  - Partial write: memory written at end of N+2, rvalid at N+3.
  - be = 0 write: rvalid at N+1.
- Exclusivity:
  - mem_read and mem_write never high together.
  - Both low in IDLE and RESP.
- Outputs of the non-granted port stay 0.
- Requester protocol:
  - A requester may deassert req only after its gnt.
  - Field changes before gnt are legal; values are sampled in the grant cycle.

Optional Feature:
- Macro DMEM_ARB_RANGE_CHECK_EN.
- Defined:
  - In IDLE, a granted request with addr[ADDR_W-1:MEM_AW+2] != 0 goes straight to RESP with no memory access.
  - pX_err = 1 and pX_rdata = 0 with rvalid.
- Undefined:
  - Upper address bits ignored; the address wraps into the 1 KiB window.
  - pX_err tied to 0.

Test Plan:
- Port 0 read, addr 0x10, memory word 4 = 0xDEADBEEF, grant at N -> p0_rvalid at N+2, p0_rdata = 0xDEADBEEF, mem_read high only in N+1.
- Port 1 write, be = 4'b0010, wdata = 0x0000AB00, addr 0x20 holding 0x11223344 -> memory word 8 = 0x1122AB44 after N+2, p1_rvalid at N+3, p1_rdata = 0.
- Both ports request every cycle with full writes -> grants alternate 0,1,0,1, starting with port 0 after reset; rvalid only on the granted port; no request starved.
- Write with be = 0 to addr 0x0 holding 0x55 -> no mem_write pulse, rvalid at N+1, word 0 stays 0x55.
- rst_n pulled low in the WR cycle of a partial write -> mem_write drops immediately, no rvalid, state IDLE; next port 0 request is granted first.
- With DMEM_ARB_RANGE_CHECK_EN, read at 0x400 -> rvalid at N+1, err = 1, rdata = 0, no mem_read. Without the macro -> reads word 0, err = 0.
